// File: rtl/control_sequencer.sv
// Microcoded control sequencer for the 8-bit bus CPU: a T0..T4 step counter plus a
// sticky halt flag, decoded with the IR opcode and ALU flags into the bus control word.
module control_sequencer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_CLOCK,
  input  logic                  i_CLEAR,
  input  logic [DATA_WIDTH-1:0] i_IR_DATA,
  input  logic                  i_FLAG_CARRY,
  input  logic                  i_FLAG_ZERO,
  output logic                  o_PC_COUNT_ENABLE,
  output logic                  o_PC_JUMP_n,
  output logic                  o_PC_WRITE_BUS,
  output logic                  o_MAR_READ_BUS_n,
  output logic                  o_RAM_READ_BUS_n,
  output logic                  o_RAM_WRITE_BUS_n,
  output logic                  o_A_READ_BUS_n,
  output logic                  o_A_WRITE_BUS_n,
  output logic                  o_B_READ_BUS_n,
  output logic                  o_IR_READ_BUS_n,
  output logic                  o_IR_WRITE_BUS_n,
  output logic                  o_ALU_WRITE_BUS_n,
  output logic                  o_ALU_SUBTRACT,
  output logic                  o_FLAGS_READ_n,
  output logic                  o_OUT_READ_BUS,
  output logic                  o_CLOCK_HALT,
  output logic [2:0]            o_STEP
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  // Active-high view of every control line; polarity is applied at the ports.
  typedef struct packed {
    logic pc_count;
    logic pc_jump;
    logic pc_write;
    logic mar_read;
    logic ram_read;
    logic ram_write;
    logic a_read;
    logic a_write;
    logic b_read;
    logic ir_read;
    logic ir_write;
    logic alu_write;
    logic alu_sub;
    logic flags_read;
    logic out_read;
  } ctrl_t;

  step_e      step_q, step_d;
  logic       halt_q, halt_d;
  logic [3:0] opcode;
  logic       last_step;
  ctrl_t      ctrl;
  logic       unused_operand;

  assign opcode         = i_IR_DATA[DATA_WIDTH-1 -: 4];
  assign unused_operand = ^i_IR_DATA[DATA_WIDTH-5:0];

  // State register
  always_ff @(posedge i_CLOCK) begin
    if (i_CLEAR) begin
      step_q <= T0;
      halt_q <= 1'b0;
    end else begin
      step_q <= step_d;
      halt_q <= halt_d;
    end
  end

  // Final step of each instruction, so short instructions end early.
  always_comb begin
    last_step = 1'b0;
    case (opcode)
      OP_LDA, OP_STA:                        last_step = (step_q == T3);
      OP_ADD, OP_SUB:                        last_step = (step_q == T4);
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT:  last_step = (step_q == T2);
      OP_HLT:                                last_step = 1'b0;
      default:                               last_step = (step_q == T1);
    endcase
  end

  // Next-state logic
  always_comb begin
    step_d = step_q;
    halt_d = halt_q;
    if (!halt_q) begin
      if (step_q == T2 && opcode == OP_HLT) begin
        halt_d = 1'b1;
      end else if (last_step) begin
        step_d = T0;
      end else begin
        case (step_q)
          T0:      step_d = T1;
          T1:      step_d = T2;
          T2:      step_d = T3;
          T3:      step_d = T4;
          default: step_d = T0;
        endcase
      end
    end
  end

  // Output decode
  always_comb begin
    ctrl = '0;
    if (!i_CLEAR && !halt_q) begin
      case (step_q)
        T0: begin
          ctrl.pc_write = 1'b1;
          ctrl.mar_read = 1'b1;
        end
        T1: begin
          ctrl.ram_write = 1'b1;
          ctrl.ir_read   = 1'b1;
          ctrl.pc_count  = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl.ir_write = 1'b1;
              ctrl.mar_read = 1'b1;
            end
            OP_LDI: begin
              ctrl.ir_write = 1'b1;
              ctrl.a_read   = 1'b1;
            end
            OP_JMP: begin
              ctrl.ir_write = 1'b1;
              ctrl.pc_jump  = 1'b1;
            end
            OP_JC: begin
              ctrl.ir_write = i_FLAG_CARRY;
              ctrl.pc_jump  = i_FLAG_CARRY;
            end
            OP_JZ: begin
              ctrl.ir_write = i_FLAG_ZERO;
              ctrl.pc_jump  = i_FLAG_ZERO;
            end
            OP_OUT: begin
              ctrl.a_write  = 1'b1;
              ctrl.out_read = 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ctrl.ram_write = 1'b1;
              ctrl.a_read    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ram_write = 1'b1;
              ctrl.b_read    = 1'b1;
              ctrl.alu_sub   = (opcode == OP_SUB);
            end
            OP_STA: begin
              ctrl.a_write  = 1'b1;
              ctrl.ram_read = 1'b1;
            end
            default: ;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            ctrl.alu_write  = 1'b1;
            ctrl.a_read     = 1'b1;
            ctrl.flags_read = 1'b1;
            ctrl.alu_sub    = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_PC_COUNT_ENABLE = ctrl.pc_count;
  assign o_PC_JUMP_n       = ~ctrl.pc_jump;
  assign o_PC_WRITE_BUS    = ctrl.pc_write;
  assign o_MAR_READ_BUS_n  = ~ctrl.mar_read;
  assign o_RAM_READ_BUS_n  = ~ctrl.ram_read;
  assign o_RAM_WRITE_BUS_n = ~ctrl.ram_write;
  assign o_A_READ_BUS_n    = ~ctrl.a_read;
  assign o_A_WRITE_BUS_n   = ~ctrl.a_write;
  assign o_B_READ_BUS_n    = ~ctrl.b_read;
  assign o_IR_READ_BUS_n   = ~ctrl.ir_read;
  assign o_IR_WRITE_BUS_n  = ~ctrl.ir_write;
  assign o_ALU_WRITE_BUS_n = ~ctrl.alu_write;
  assign o_ALU_SUBTRACT    = ctrl.alu_sub;
  assign o_FLAGS_READ_n    = ~ctrl.flags_read;
  assign o_OUT_READ_BUS    = ctrl.out_read;
  assign o_CLOCK_HALT      = halt_q & ~i_CLEAR;
  assign o_STEP            = i_CLEAR ? '0 : step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven bench for control_sequencer: per-cycle vectors with expected control
// words flow through a scoreboard queue and are compared mid-cycle.
module tb_control_sequencer;

  localparam logic [14:0] PCE  = 15'h0001;
  localparam logic [14:0] PCJ  = 15'h0002;
  localparam logic [14:0] PCW  = 15'h0004;
  localparam logic [14:0] MAR  = 15'h0008;
  localparam logic [14:0] RAMR = 15'h0010;
  localparam logic [14:0] RAMW = 15'h0020;
  localparam logic [14:0] AR   = 15'h0040;
  localparam logic [14:0] AW   = 15'h0080;
  localparam logic [14:0] BR   = 15'h0100;
  localparam logic [14:0] IRR  = 15'h0200;
  localparam logic [14:0] IRW  = 15'h0400;
  localparam logic [14:0] ALUW = 15'h0800;
  localparam logic [14:0] SUB  = 15'h1000;
  localparam logic [14:0] FLG  = 15'h2000;
  localparam logic [14:0] OUTR = 15'h4000;
  localparam logic [14:0] F0   = PCW | MAR;
  localparam logic [14:0] F1   = RAMW | IRR | PCE;
  localparam logic [14:0] DRV  = PCW | RAMW | AW | IRW | ALUW;

  typedef struct {
    logic        clr;
    logic [7:0]  ir;
    logic        c;
    logic        z;
    logic [14:0] ctrl;
    logic [2:0]  step;
    logic        halt;
  } vec_t;

  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic [7:0]  ir = 8'h2A;
  logic        carry = 1'b0;
  logic        zero = 1'b0;
  logic        pce, pcj_n, pcw, mar_n, ramr_n, ramw_n, ar_n, aw_n, br_n;
  logic        irr_n, irw_n, aluw_n, alusub, flg_n, outr, halt;
  logic [2:0]  step;
  logic [14:0] obs;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  control_sequencer #(.DATA_WIDTH(8)) dut (
    .i_CLOCK          (clk),
    .i_CLEAR          (clear),
    .i_IR_DATA        (ir),
    .i_FLAG_CARRY     (carry),
    .i_FLAG_ZERO      (zero),
    .o_PC_COUNT_ENABLE(pce),
    .o_PC_JUMP_n      (pcj_n),
    .o_PC_WRITE_BUS   (pcw),
    .o_MAR_READ_BUS_n (mar_n),
    .o_RAM_READ_BUS_n (ramr_n),
    .o_RAM_WRITE_BUS_n(ramw_n),
    .o_A_READ_BUS_n   (ar_n),
    .o_A_WRITE_BUS_n  (aw_n),
    .o_B_READ_BUS_n   (br_n),
    .o_IR_READ_BUS_n  (irr_n),
    .o_IR_WRITE_BUS_n (irw_n),
    .o_ALU_WRITE_BUS_n(aluw_n),
    .o_ALU_SUBTRACT   (alusub),
    .o_FLAGS_READ_n   (flg_n),
    .o_OUT_READ_BUS   (outr),
    .o_CLOCK_HALT     (halt),
    .o_STEP           (step)
  );

  assign obs = {outr, ~flg_n, alusub, ~aluw_n, ~irw_n, ~irr_n, ~br_n, ~aw_n,
                ~ar_n, ~ramw_n, ~ramr_n, ~mar_n, pcw, ~pcj_n, pce};

  function automatic void add(input logic clr, input logic [7:0] i, input logic c,
                              input logic z, input logic [14:0] ctl,
                              input logic [2:0] st, input logic h);
    vec_t v;
    v.clr = clr; v.ir = i; v.c = c; v.z = z; v.ctrl = ctl; v.step = st; v.halt = h;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic [14:0] got,
                       input logic [14:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s cycle %0d: got %h want %h", name, idx, got, want);
  endtask

  // One cycle: drive after the rising edge, compare at the falling edge.
  task automatic run(input vec_t v, input int idx);
    vec_t e;
    @(posedge clk);
    #1;
    clear = v.clr; ir = v.ir; carry = v.c; zero = v.z;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    check("ctrl", idx, obs, e.ctrl);
    check("step", idx, {12'd0, step}, {12'd0, e.step});
    check("halt", idx, {14'd0, halt}, {14'd0, e.halt});
    check("bus_excl", idx, {11'd0, 4'($countones(obs & DRV)) <= 4'd1 ? 4'd1 : 4'd0},
          15'd1);
  endtask

  task automatic run1(input logic clr, input logic [7:0] i, input logic [14:0] ctl,
                      input logic [2:0] st, input logic h, input int idx);
    vec_t v;
    v.clr = clr; v.ir = i; v.c = 1'b0; v.z = 1'b0; v.ctrl = ctl; v.step = st; v.halt = h;
    run(v, idx);
  endtask

  initial begin
    // reset, then LDI
    add(1, 8'h2A, 0, 0, '0, 0, 0);
    add(1, 8'h2A, 0, 0, '0, 0, 0);
    add(0, 8'h57, 0, 0, F0, 0, 0);
    add(0, 8'h57, 0, 0, F1, 1, 0);
    add(0, 8'h57, 0, 0, IRW | AR, 2, 0);
    // ADD then SUB
    add(0, 8'h2F, 0, 0, F0, 0, 0);
    add(0, 8'h2F, 0, 0, F1, 1, 0);
    add(0, 8'h2F, 0, 0, IRW | MAR, 2, 0);
    add(0, 8'h2F, 0, 0, RAMW | BR, 3, 0);
    add(0, 8'h2F, 0, 0, ALUW | AR | FLG, 4, 0);
    add(0, 8'h3F, 0, 0, F0, 0, 0);
    add(0, 8'h3F, 0, 0, F1, 1, 0);
    add(0, 8'h3F, 0, 0, IRW | MAR, 2, 0);
    add(0, 8'h3F, 0, 0, RAMW | BR | SUB, 3, 0);
    add(0, 8'h3F, 0, 0, ALUW | AR | FLG | SUB, 4, 0);
    // JC taken / not taken
    add(0, 8'h73, 1, 0, F0, 0, 0);
    add(0, 8'h73, 1, 0, F1, 1, 0);
    add(0, 8'h73, 1, 0, IRW | PCJ, 2, 0);
    add(0, 8'h73, 0, 1, F0, 0, 0);
    add(0, 8'h73, 0, 1, F1, 1, 0);
    add(0, 8'h73, 0, 1, '0, 2, 0);
    // JZ taken / not taken
    add(0, 8'h80, 0, 1, F0, 0, 0);
    add(0, 8'h80, 0, 1, F1, 1, 0);
    add(0, 8'h80, 0, 1, IRW | PCJ, 2, 0);
    add(0, 8'h85, 1, 0, F0, 0, 0);
    add(0, 8'h85, 1, 0, F1, 1, 0);
    add(0, 8'h85, 1, 0, '0, 2, 0);
    // illegal opcode runs as a 2-cycle NOP
    add(0, 8'hB0, 0, 0, F0, 0, 0);
    add(0, 8'hB0, 0, 0, F1, 1, 0);
    // LDA, STA, OUT, JMP, NOP
    add(0, 8'h1C, 0, 0, F0, 0, 0);
    add(0, 8'h1C, 0, 0, F1, 1, 0);
    add(0, 8'h1C, 0, 0, IRW | MAR, 2, 0);
    add(0, 8'h1C, 0, 0, RAMW | AR, 3, 0);
    add(0, 8'h4C, 0, 0, F0, 0, 0);
    add(0, 8'h4C, 0, 0, F1, 1, 0);
    add(0, 8'h4C, 0, 0, IRW | MAR, 2, 0);
    add(0, 8'h4C, 0, 0, AW | RAMR, 3, 0);
    add(0, 8'hE0, 0, 0, F0, 0, 0);
    add(0, 8'hE0, 0, 0, F1, 1, 0);
    add(0, 8'hE0, 0, 0, AW | OUTR, 2, 0);
    add(0, 8'h63, 0, 0, F0, 0, 0);
    add(0, 8'h63, 0, 0, F1, 1, 0);
    add(0, 8'h63, 0, 0, IRW | PCJ, 2, 0);
    add(0, 8'h00, 0, 0, F0, 0, 0);
    add(0, 8'h00, 0, 0, F1, 1, 0);

    foreach (vecs[i]) run(vecs[i], i);

    // halt: frozen at step 2 with all controls idle regardless of IR
    run1(0, 8'hF0, F0, 0, 0, 100);
    run1(0, 8'hF0, F1, 1, 0, 101);
    run1(0, 8'hF0, '0, 2, 0, 102);
    for (int k = 0; k < 10; k++) run1(0, 8'h2F, '0, 2, 1, 103 + k);
    run1(1, 8'h2F, '0, 0, 0, 113);
    // restart, then clear during ADD T3
    run1(0, 8'h2F, F0, 0, 0, 114);
    run1(0, 8'h2F, F1, 1, 0, 115);
    run1(0, 8'h2F, IRW | MAR, 2, 0, 116);
    run1(1, 8'h2F, '0, 0, 0, 117);
    run1(0, 8'hB0, F0, 0, 0, 118);
    run1(0, 8'hB0, F1, 1, 0, 119);
    run1(0, 8'hB0, F0, 0, 0, 120);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit bus CPU: steps a microstep counter and decodes the instruction register opcode plus ALU flags into the bus control word.
- Replaces the hardwired control assignments in the top level.
- Sits upstream of the program counter, registers, instruction register, memory and output modules, and downstream of the instruction register it consumes.
- i_CLOCK is driven from CLOCK_n, so control lines settle half a cycle before the datapath's rising CLOCK edge.

Parameters:
DATA_WIDTH, 8, bus/IR width; opcode = i_IR_DATA[DATA_WIDTH-1:DATA_WIDTH-4], operand = low 4 bits (not used here).

Ports:
i_CLOCK  in  1  single clock; all state changes on rising edge
i_CLEAR  in  1  synchronous reset, active-high
i_IR_DATA  in  DATA_WIDTH  instruction register contents
i_FLAG_CARRY  in  1  latched ALU carry flag
i_FLAG_ZERO  in  1  latched ALU zero flag
o_PC_COUNT_ENABLE  out  1  PC increment (active-high)
o_PC_JUMP_n  out  1  PC load from bus (active-low)
o_PC_WRITE_BUS  out  1  PC drives bus (active-high)
o_MAR_READ_BUS_n  out  1  memory address register loads from bus
o_RAM_READ_BUS_n  out  1  RAM loads from bus
o_RAM_WRITE_BUS_n  out  1  RAM drives bus
o_A_READ_BUS_n / o_A_WRITE_BUS_n  out  1 each  A register load / drive
o_B_READ_BUS_n  out  1  B register load
o_IR_READ_BUS_n / o_IR_WRITE_BUS_n  out  1 each  IR load / drive operand
o_ALU_WRITE_BUS_n  out  1  ALU result drives bus
o_ALU_SUBTRACT  out  1  ALU subtract select
o_FLAGS_READ_n  out  1  flags register latches
o_OUT_READ_BUS  out  1  output display loads from bus (active-high)
o_CLOCK_HALT  out  1  halt request to clock module, sticky
o_STEP  out  3  current microstep, debug

Behaviour:
- State: 3-bit step register (T0..T4) and halt flag. Control outputs are a combinational decode of step, opcode and flags; no other state.
- Inactive levels: _n outputs 1; active-high outputs 0.
- Reset: i_CLEAR sampled high -> step=0, halt=0 on that edge. While i_CLEAR is high, all control outputs are forced inactive and o_CLOCK_HALT=0. Reset mid-instruction abandons the instruction; the first cycle after release is T0.
- Fetch is common to all opcodes:
  - T0: PC_WRITE_BUS, MAR_READ_n.
  - T1: RAM_WRITE_n, IR_READ_n, PC_COUNT_ENABLE.
- Execute steps (any step not listed is empty):
  - NOP 0x0: no execute steps.
  - LDA 0x1: T2 IR_WRITE_n+MAR_READ_n; T3 RAM_WRITE_n+A_READ_n.
  - ADD 0x2: T2 IR_WRITE_n+MAR_READ_n; T3 RAM_WRITE_n+B_READ_n; T4 ALU_WRITE_n+A_READ_n+FLAGS_READ_n.
  - SUB 0x3: as ADD, plus ALU_SUBTRACT=1 in T3 and T4.
  - STA 0x4: T2 IR_WRITE_n+MAR_READ_n; T3 A_WRITE_n+RAM_READ_n.
  - LDI 0x5: T2 IR_WRITE_n+A_READ_n.
  - JMP 0x6: T2 IR_WRITE_n+PC_JUMP_n.
  - JC 0x7: T2 IR_WRITE_n+PC_JUMP_n only if i_FLAG_CARRY=1, else empty.
  - JZ 0x8: as JC using i_FLAG_ZERO.
  - OUT 0xE: T2 A_WRITE_n+OUT_READ_BUS.
  - HLT 0xF: T2 sets halt.
  - 0x9-0xD: executed as NOP.
- Step advance: the step increments each edge. The last step of an instruction returns to T0 on the next edge, giving an early end.
  - Instruction lengths: NOP/illegal 2 cycles, LDI/JMP/JC/JZ/OUT 3 cycles, LDA/STA 4 cycles, ADD/SUB 5 cycles.
  - A conditional jump not taken still takes 3 cycles.
  - Step never exceeds 4.
- Flags are sampled combinationally during T2 only.
- Halt: on the edge leaving HLT T2, halt=1, step stays at 2 and is frozen. o_CLOCK_HALT=1 and all other controls are inactive until i_CLEAR.
- Bus exclusivity: at most one *_WRITE_BUS driver is active in any step. The bench asserts this as an invariant.
- o_STEP = step register at all times, and 0 during reset.

Test Plan:
- Reset: hold i_CLEAR 2 edges with IR=0x2A -> all controls inactive, o_STEP=0, o_CLOCK_HALT=0. The first post-release cycle shows PC_WRITE_BUS=1 and MAR_READ_n=0.
- Fetch+LDI: IR=0x57 from T2 -> T0/T1 fetch words exactly as specified. T2 gives IR_WRITE_n=0 and A_READ_n=0, and the next cycle has o_STEP=0 (3-cycle instruction).
- ADD vs SUB: IR=0x2F, then 0x3F -> 5-cycle sequence with T4 ALU_WRITE_n=A_READ_n=FLAGS_READ_n=0. ALU_SUBTRACT=0 for ADD and 1 in T3/T4 for SUB.
- Conditional jumps: JC (0x73) with carry=1 gives PC_JUMP_n=0 in T2; with carry=0, PC_JUMP_n stays 1 and the instruction still returns to T0 after 3 cycles. Repeat for JZ (0x8x) with zero.
- Halt: IR=0xF0 -> o_CLOCK_HALT rises after T2 and stays 1, with o_STEP frozen at 2, for 10 extra clocks. Asserting i_CLEAR clears it and the sequencer restarts at T0.
- Reset mid-instruction and illegal opcode: i_CLEAR during ADD T3 -> the next cycle is T0 with nothing active during reset. IR=0xB0 -> 2-cycle NOP. The single-bus-driver invariant holds throughout all scenarios.
